// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the IF-stage branch target buffer.
// Counter encodings follow the usual 2-bit saturating scheme.
package btb_predictor_pkg;

  localparam int unsigned WORD_SIZE = 16;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/btb_predictor_sat_counter_2b.sv
// 2-bit saturating direction counter: next-state function only.
module sat_counter_2b
  import btb_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with combinational lookup and
// registered training from the ID stage.
module btb_predictor #(
  parameter int unsigned WORD_SIZE  = btb_predictor_pkg::WORD_SIZE,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = WORD_SIZE - INDEX_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WORD_SIZE-1:0] i_pc_if,
  output logic [WORD_SIZE-1:0] o_pred_pc,
  output logic                 o_pred_hit,
  output logic                 o_pred_taken,
  input  logic                 i_upd_en,
  input  logic [WORD_SIZE-1:0] i_upd_pc,
  input  logic [WORD_SIZE-1:0] i_upd_target,
  input  logic                 i_upd_taken,
  input  logic                 i_upd_is_jump
);
  import btb_predictor_pkg::*;

  localparam int unsigned Entries = 1 << INDEX_BITS;

  logic                 r_valid  [Entries];
  logic [TAG_BITS-1:0]  r_tag    [Entries];
  logic [WORD_SIZE-1:0] r_target [Entries];
  logic [1:0]           r_ctr    [Entries];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [WORD_SIZE-1:0]  w_pc_inc;
  logic                  w_hit;
  logic                  w_taken;

  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  logic [1:0]            w_upd_ctr_next;

  assign w_idx    = i_pc_if[INDEX_BITS-1:0];
  assign w_tag    = i_pc_if[WORD_SIZE-1:INDEX_BITS];
  // Sequential fall-through wraps naturally at the word width.
  assign w_pc_inc = i_pc_if + {{(WORD_SIZE-1){1'b0}}, 1'b1};
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_taken  = w_hit && r_ctr[w_idx][1];

  assign o_pred_hit   = w_hit;
  assign o_pred_taken = w_taken;
  assign o_pred_pc    = w_taken ? r_target[w_idx] : w_pc_inc;

  assign w_upd_idx = i_upd_pc[INDEX_BITS-1:0];
  assign w_upd_tag = i_upd_pc[WORD_SIZE-1:INDEX_BITS];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  sat_counter_2b u_sat_counter (
    .i_ctr   (r_ctr[w_upd_idx]),
    .i_taken (i_upd_taken),
    .o_ctr   (w_upd_ctr_next)
  );

  // Tags and targets are don't-care while invalid, so only valid/ctr reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < Entries; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_RESET;
      end
    end else if (i_upd_en) begin
      if (i_upd_is_jump) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_ST;
      end else if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_upd_ctr_next;
        if (i_upd_taken) r_target[w_upd_idx] <= i_upd_target;
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_btb_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] pc_if;
  logic [15:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic        upd_en;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;

  int n_pass;
  int n_total;

  // Reference model: one slot per index, counter kept as an integer 0..3.
  bit        m_valid  [16];
  bit [11:0] m_tag    [16];
  bit [15:0] m_target [16];
  int        m_ctr    [16];

  btb_predictor dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_pc_if       (pc_if),
    .o_pred_pc     (pred_pc),
    .o_pred_hit    (pred_hit),
    .o_pred_taken  (pred_taken),
    .i_upd_en      (upd_en),
    .i_upd_pc      (upd_pc),
    .i_upd_target  (upd_target),
    .i_upd_taken   (upd_taken),
    .i_upd_is_jump (upd_is_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_train(bit [15:0] pc, bit [15:0] tgt, bit tk, bit jmp);
    int  idx;
    bit  hit;
    idx = int'(pc % 16);
    hit = m_valid[idx] && (m_tag[idx] == pc[15:4]);
    if (jmp) begin
      m_valid[idx] = 1'b1; m_tag[idx] = pc[15:4]; m_target[idx] = tgt; m_ctr[idx] = 3;
    end else if (hit) begin
      if (tk) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[idx] = 1'b1; m_tag[idx] = pc[15:4]; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
  endfunction

  // Returns {hit, taken, pred_pc}.
  function automatic logic [17:0] model_predict(bit [15:0] pc);
    int       idx;
    bit       hit;
    bit       tk;
    bit [15:0] nxt;
    idx = int'(pc % 16);
    hit = m_valid[idx] && (m_tag[idx] == pc[15:4]);
    tk  = hit && (m_ctr[idx] >= 2);
    nxt = 16'((32'(pc) + 1) % 65536);
    return {hit, tk, tk ? m_target[idx] : nxt};
  endfunction

  // Drive one training pulse; inputs change 1 time unit after the edge.
  task automatic train(input bit [15:0] pc, input bit [15:0] tgt, input bit tk, input bit jmp);
    upd_en = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_jump = jmp;
    @(posedge clk);
    #1;
    model_train(pc, tgt, tk, jmp);
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    pc_if = 16'h0010; #1;
    exp = {1'b0, 1'b0, 16'h0011};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL reset_lookup got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  task automatic test_alloc();
    logic [17:0] exp;
    train(16'h0010, 16'h0040, 1'b1, 1'b0);
    pc_if = 16'h0010; #1;
    exp = {1'b1, 1'b1, 16'h0040};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL alloc_taken got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  // Walks the counter from 10 down to 00, back up to 11, and down again.
  task automatic test_counter();
    bit         tk_seq  [12];
    bit [15:0]  tgt_seq [12];
    logic [17:0] exp_seq [12];
    logic [17:0] want_t, want_n;
    want_t = {1'b1, 1'b1, 16'h0040};
    want_n = {1'b1, 1'b0, 16'h0011};
    tk_seq = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    exp_seq = '{want_n, want_n, want_n, want_n, want_t, want_n, want_n,
                want_n, want_t, want_t, want_t, want_t};
    for (int i = 0; i < 12; i++) tgt_seq[i] = tk_seq[i] ? 16'h0040 : 16'h0077;
    pc_if = 16'h0010;
    for (int i = 0; i < 12; i++) begin
      train(16'h0010, tgt_seq[i], tk_seq[i], 1'b0);
      #1;
      n_total++;
      if ({pred_hit, pred_taken, pred_pc} !== exp_seq[i])
        $display("FAIL counter_step%0d got=%h want=%h", i,
                 {pred_hit, pred_taken, pred_pc}, exp_seq[i]);
      else n_pass++;
    end
    // Counter now 10: one more not-taken drops to 01.
    train(16'h0010, 16'h0077, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== want_n)
      $display("FAIL counter_sat_high got=%h want=%h", {pred_hit, pred_taken, pred_pc}, want_n);
    else n_pass++;
  endtask

  task automatic test_jump_alias();
    logic [17:0] exp;
    train(16'h0023, 16'h0100, 1'b0, 1'b1);
    pc_if = 16'h0023; #1;
    exp = {1'b1, 1'b1, 16'h0100};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL jump_hit got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    // Counter 11: a not-taken still predicts taken, proving the jump set it strong.
    train(16'h0023, 16'h0999, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL jump_strong got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    train(16'h0033, 16'h0200, 1'b1, 1'b0);
    pc_if = 16'h0023; #1;
    exp = {1'b0, 1'b0, 16'h0024};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL alias_evicted got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    pc_if = 16'h0033; #1;
    exp = {1'b1, 1'b1, 16'h0200};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL alias_owner got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  task automatic test_no_alloc_wrap();
    logic [17:0] exp;
    train(16'h0005, 16'h0300, 1'b0, 1'b0);
    pc_if = 16'h0005; #1;
    exp = {1'b0, 1'b0, 16'h0006};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL no_alloc got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    pc_if = 16'hFFFF; #1;
    exp = {1'b0, 1'b0, 16'h0000};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL wrap got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [17:0] exp;
    // 0x0010 currently predicts not-taken (counter 01); a jump makes it taken.
    pc_if = 16'h0010;
    upd_en = 1'b1; upd_pc = 16'h0010; upd_target = 16'h0555;
    upd_taken = 1'b0; upd_is_jump = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 16'h0011};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL rbw_old got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    @(posedge clk); #1;
    upd_en = 1'b0;
    model_train(16'h0010, 16'h0555, 1'b0, 1'b1);
    #1;
    exp = {1'b1, 1'b1, 16'h0555};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL rbw_new got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  task automatic test_reset_with_update();
    logic [17:0] exp;
    reset = 1'b1;
    upd_en = 1'b1; upd_pc = 16'h0050; upd_target = 16'h0600;
    upd_taken = 1'b1; upd_is_jump = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; upd_en = 1'b0;
    model_reset();
    pc_if = 16'h0050; #1;
    exp = {1'b0, 1'b0, 16'h0051};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL reset_drops_upd got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
    pc_if = 16'h0010; #1;
    exp = {1'b0, 1'b0, 16'h0011};
    n_total++;
    if ({pred_hit, pred_taken, pred_pc} !== exp)
      $display("FAIL reset_clears got=%h want=%h", {pred_hit, pred_taken, pred_pc}, exp);
    else n_pass++;
  endtask

  // Random training and lookups over a few aliasing tags, checked every cycle
  // before the edge so read-before-write is exercised too.
  task automatic test_random();
    logic [17:0] exp;
    bit [15:0]   rpc, rtgt;
    bit          ren, rtk, rjmp;
    for (int i = 0; i < 400; i++) begin
      rpc  = {10'h000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      rtgt = 16'($urandom);
      ren  = ($urandom_range(0, 3) != 0);
      rtk  = 1'($urandom);
      rjmp = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) pc_if = 16'($urandom);
      else pc_if = {10'h000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      upd_en = ren; upd_pc = rpc; upd_target = rtgt; upd_taken = rtk; upd_is_jump = rjmp;
      #1;
      exp = model_predict(pc_if);
      n_total++;
      if ({pred_hit, pred_taken, pred_pc} !== exp)
        $display("FAIL random_%0d pc=%h got=%h want=%h", i, pc_if,
                 {pred_hit, pred_taken, pred_pc}, exp);
      else n_pass++;
      @(posedge clk); #1;
      if (ren) model_train(rpc, rtgt, rtk, rjmp);
    end
    upd_en = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0; pc_if = 16'h0000;
    upd_en = 1'b0; upd_pc = 16'h0000; upd_target = 16'h0000;
    upd_taken = 1'b0; upd_is_jump = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_alloc();
    test_counter();
    test_jump_alias();
    test_no_alloc_wrap();
    test_same_cycle();
    test_reset_with_update();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
